muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have parameter XLEN, default 64: operand and result width; only 64 is supported.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (reset==0 resets).
REQ-004 The block SHALL have port start, input, 1 bit: execute stage holds a valid mul/div op; held high until done.
REQ-005 The block SHALL have port op, input, 3 bits: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 The block SHALL have port word, input, 1 bit: 32-bit variant (valid with MUL, DIV, DIVU, REM, REMU only).
REQ-007 The block SHALL have ports a and b, input, XLEN bits each: forwarded source operands, sampled at start acceptance.
REQ-008 The block SHALL have port flush, input, 1 bit: abort current operation.
REQ-009 The block SHALL have port e_wait, output, 1 bit: pipeline stall request.
REQ-010 The block SHALL have port done, output, 1 bit: result valid this cycle (one-cycle pulse).
REQ-011 The block SHALL have port result, output, XLEN bits: final result, valid when done==1.

Function
REQ-012 The block SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-013 IDLE: start==1 and flush==0 SHALL latch op, word and operands, load iteration counter N (64; 32 when word==1), and go to CALC; if divide op with divisor (after word truncation) ==0, SHALL go directly to DONE.
REQ-014 CALC: one radix-2 step per cycle (shift-add for multiply, restoring shift-subtract on magnitudes for divide); counter decrements; after the N-th step SHALL go to FIX.
REQ-015 FIX: sign correction and result selection in one cycle, then SHALL go to DONE.
REQ-016 DONE: done=1, result driven from a registered value; SHALL go to IDLE next cycle regardless of start (start is ignored in DONE).
REQ-017 Latency: accept at cycle 0 -> done at cycle N+2 (66 for 64-bit, 34 for word); divide-by-zero -> done at cycle 1.
REQ-018 e_wait SHALL equal (state==IDLE && start && !flush) || state==CALC || state==FIX; e_wait SHALL be 0 in DONE.
REQ-019 Signedness: MULH both signed; MULHSU a signed, b unsigned; MULHU, DIVU, REMU unsigned; DIV, REM signed; MUL sign-agnostic.
REQ-020 Operands in word mode: low 32 bits, sign-extended for signed ops, zero-extended otherwise; result: low 32 bits sign-extended to 64.
REQ-021 MUL SHALL return product[63:0]; MULH* SHALL return product[127:64].
REQ-022 Division SHALL truncate toward zero; remainder sign SHALL equal dividend sign.
REQ-023 Divide by zero: quotient SHALL be all ones (word: 0xFFFFFFFFFFFFFFFF after extension); remainder SHALL be the dividend (word-extended).
REQ-024 Signed overflow (MIN / -1): quotient SHALL be MIN, remainder 0, without special-case latency.
REQ-025 flush==1 in any state SHALL force IDLE next cycle with no done pulse; flush has priority over start.
REQ-026 Latched operands SHALL be immune to a/b changes after acceptance.

Reset
REQ-027 While reset==0, state SHALL be IDLE, counter 0, internal registers 0, done=0, result=0, and e_wait SHALL be 0 (start ignored during reset).
REQ-028 Reset asserted mid-operation SHALL abort immediately; after release, block SHALL be in IDLE and no done SHALL appear for the aborted op.

Verification
REQ-029 DIV a=100, b=-7 (64-bit) -> done at cycle 66, result 0xFFFFFFFFFFFFFFF2 (-14); REM same operands -> 2; e_wait=1 cycles 0-65.
REQ-030 DIV, word=1, a=0x0000000080000000, b=0xFFFFFFFFFFFFFFFF -> done at cycle 34, result 0xFFFFFFFF80000000; REM -> 0.
REQ-031 MULHU a=0xFFFFFFFFFFFFFFFF, b=2 -> result 1; MULH same operands -> 0xFFFFFFFFFFFFFFFF; MUL -> 0xFFFFFFFFFFFFFFFE.
REQ-032 DIVU a=5, b=0 -> done at cycle 1, result 0xFFFFFFFFFFFFFFFF; REMU -> 5.
REQ-033 DIV started, flush pulsed at cycle 10 -> IDLE at cycle 11, e_wait=0 with start low, no done; next start completes normally.
REQ-034 reset driven low at cycle 20 of MUL -> outputs 0 immediately; after release, start high -> full fresh operation, done at cycle 66.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: execute-stage handshake and operand/result bus for the sequential mul/div unit.
interface muldiv_seq_if #(parameter int XLEN = 64);
    logic            start;
    logic [2:0]      op;
    logic            word;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            e_wait;
    logic            done;
    logic [XLEN-1:0] result;
    modport master(output start, op, word, a, b, flush, input e_wait, done, result);
    modport slave(input start, op, word, a, b, flush, output e_wait, done, result);
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: radix-2 sequential multiplier/divider (RV64 M-extension ops, incl. word variants).
module muldiv_seq #(parameter int XLEN = 64) (
    input logic         clk,
    input logic         reset,
    muldiv_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} stateT;

    stateT state, nextState;
    logic [2:0] opR;
    logic wordR, negR, remNegR;
    logic [6:0] cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0] mplr, mcand, resReg;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

    logic signA, signB, aNeg, bNeg, divZero, accept;
    logic [XLEN-1:0] aExt, bExt, aMag, bMag, dzVal;
    assign signA = bus.op == 3'd1 || bus.op == 3'd2 || bus.op == 3'd4 || bus.op == 3'd6;
    assign signB = bus.op == 3'd1 || bus.op == 3'd4 || bus.op == 3'd6;
    assign aExt = bus.word ? {{(XLEN-32){signA & bus.a[31]}}, bus.a[31:0]} : bus.a;
    assign bExt = bus.word ? {{(XLEN-32){signB & bus.b[31]}}, bus.b[31:0]} : bus.b;
    assign aNeg = signA & aExt[XLEN-1];
    assign bNeg = signB & bExt[XLEN-1];
    assign aMag = aNeg ? -aExt : aExt;
    assign bMag = bNeg ? -bExt : bExt;
    assign divZero = bus.op[2] && bExt == '0;
    assign dzVal = bus.op[1] ? aExt : '1;
    assign accept = state == IDLE && bus.start && !bus.flush;

    // Word ops preload the first operand in the top half so N=32 steps consume exactly its low bits.
    logic [2*XLEN-1:0] mulSum, prod;
    logic [XLEN:0] divR, divD;
    logic divGe;
    logic [XLEN-1:0] quo, rem, fixVal;
    assign mulSum = {acc[2*XLEN-2:0], 1'b0} + (mplr[XLEN-1] ? {{XLEN{1'b0}}, mcand} : '0);
    assign divR = {acc[XLEN-1:0], mplr[XLEN-1]};
    assign divD = divR - {1'b0, mcand};
    assign divGe = divR >= {1'b0, mcand};
    assign prod = negR ? -acc : acc;
    assign quo = negR ? -mplr : mplr;
    assign rem = remNegR ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign fixVal = opR[2] ? (opR[1] ? rem : quo) : (opR == 3'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: nextState = accept ? (divZero ? DONE : CALC) : IDLE;
            CALC: nextState = cnt == 7'd1 ? FIX : CALC;
            FIX:  nextState = DONE;
            DONE: nextState = IDLE;
        endcase
        if (bus.flush) nextState = IDLE;
    end

    assign bus.e_wait = reset && (accept || state == CALC || state == FIX);
    assign bus.done = state == DONE;
    assign bus.result = resReg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opR <= '0;
            wordR <= 1'b0;
            negR <= 1'b0;
            remNegR <= 1'b0;
            cnt <= '0;
            acc <= '0;
            mplr <= '0;
            mcand <= '0;
            resReg <= '0;
        end else if (accept) begin
            opR <= bus.op;
            wordR <= bus.word;
            negR <= aNeg ^ bNeg;
            remNegR <= aNeg;
            cnt <= bus.word ? 7'd32 : 7'd64;
            acc <= '0;
            mplr <= bus.word ? aMag << 32 : aMag;
            mcand <= bMag;
            if (divZero) resReg <= bus.word ? sext32(dzVal) : dzVal;
        end else if (state == CALC) begin
            cnt <= cnt - 7'd1;
            acc <= opR[2] ? {{(XLEN-1){1'b0}}, divGe ? divD : divR} : mulSum;
            mplr <= opR[2] ? {mplr[XLEN-2:0], divGe} : mplr << 1;
        end else if (state == FIX) begin
            resReg <= wordR ? sext32(fixVal) : fixVal;
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vectors for muldiv_seq covering latency, signedness, word mode, flush and reset.
module tb_muldiv_seq;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int failures = 0;

    muldiv_seq_if #(.XLEN(64)) bus();
    muldiv_seq #(.XLEN(64)) dut(.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drives one op, holds start until done, scrambles a/b after acceptance.
    task automatic runOp(input string tag, input logic [2:0] o, input logic w,
                         input logic [63:0] x, input logic [63:0] y, input int lat, input logic [63:0] exp);
        int cyc;
        int doneAt;
        int ewErr;
        logic [63:0] got;
        cyc = 0;
        doneAt = -1;
        ewErr = 0;
        got = '0;
        @(negedge clk);
        bus.op = o;
        bus.word = w;
        bus.a = x;
        bus.b = y;
        bus.flush = 1'b0;
        bus.start = 1'b1;
        #1;
        if (bus.e_wait !== 1'b1) ewErr++;
        while (doneAt < 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.done === 1'b1) begin
                doneAt = cyc;
                got = bus.result;
                if (bus.e_wait !== 1'b0) ewErr++;
            end else if (bus.e_wait !== 1'b1) ewErr++;
            if (cyc == 1) begin
                bus.a = ~x;
                bus.b = x ^ y ^ 64'h5A5A_A5A5_0F0F_F0F0;
            end
        end
        bus.start = 1'b0;
        check({tag, "_lat"}, 64'(doneAt), 64'(lat));
        check({tag, "_res"}, got, exp);
        check({tag, "_ewait"}, 64'(ewErr), 64'd0);
        @(negedge clk);
        check({tag, "_idle"}, {62'd0, bus.done, bus.e_wait}, 64'd0);
    endtask

    initial begin
        int seen;
        bus.start = 1'b1;
        bus.op = 3'd0;
        bus.word = 1'b0;
        bus.a = 64'd3;
        bus.b = 64'd5;
        bus.flush = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_result", bus.result, 64'd0);
        check("rst_ewait", {63'd0, bus.e_wait}, 64'd0);
        bus.start = 1'b0;
        reset = 1'b1;

        runOp("div_100_m7", 3'd4, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 66, 64'hFFFF_FFFF_FFFF_FFF2);
        runOp("rem_100_m7", 3'd6, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 66, 64'd2);
        runOp("divw_min_m1", 3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 34, 64'hFFFF_FFFF_8000_0000);
        runOp("remw_min_m1", 3'd6, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 34, 64'd0);
        runOp("mulhu", 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 66, 64'd1);
        runOp("mulh", 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 66, 64'hFFFF_FFFF_FFFF_FFFF);
        runOp("mul", 3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 66, 64'hFFFF_FFFF_FFFF_FFFE);
        runOp("mulhsu", 3'd2, 1'b0, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, 64'd1);
        runOp("mulhsu_neg", 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 66, 64'hFFFF_FFFF_FFFF_FFFF);
        runOp("divu_dz", 3'd5, 1'b0, 64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        runOp("remu_dz", 3'd7, 1'b0, 64'd5, 64'd0, 1, 64'd5);
        runOp("remw_dz", 3'd6, 1'b1, 64'h0000_0000_8000_0005, 64'h0000_0001_0000_0000, 1, 64'hFFFF_FFFF_8000_0005);
        runOp("divu_100_7", 3'd5, 1'b0, 64'd100, 64'd7, 66, 64'd14);
        runOp("mulw", 3'd0, 1'b1, 64'hDEAD_0000_0001_0000, 64'h0000_0000_0000_8000, 34, 64'hFFFF_FFFF_8000_0000);
        runOp("div_min_m1", 3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 66, 64'h8000_0000_0000_0000);
        runOp("rem_min_m1", 3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 66, 64'd0);
        runOp("div_m7_2", 3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 66, 64'hFFFF_FFFF_FFFF_FFFD);
        runOp("rem_m7_2", 3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 66, 64'hFFFF_FFFF_FFFF_FFFF);
        runOp("divuw", 3'd5, 1'b1, 64'h1234_0000_FFFF_FFFF, 64'd2, 34, 64'h0000_0000_7FFF_FFFF);
        runOp("divw_m1_2", 3'd4, 1'b1, 64'h1234_0000_FFFF_FFFF, 64'd2, 34, 64'd0);

        @(negedge clk);
        bus.op = 3'd4;
        bus.word = 1'b0;
        bus.a = 64'd100;
        bus.b = 64'hFFFF_FFFF_FFFF_FFF9;
        bus.start = 1'b1;
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        check("flush_ewait", {63'd0, bus.e_wait}, 64'd0);
        check("flush_done", {63'd0, bus.done}, 64'd0);
        bus.flush = 1'b0;
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
        check("flush_nodone", 64'(seen), 64'd0);
        runOp("div_after_flush", 3'd4, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 66, 64'hFFFF_FFFF_FFFF_FFF2);

        @(negedge clk);
        bus.op = 3'd0;
        bus.word = 1'b0;
        bus.a = 64'd3;
        bus.b = 64'd5;
        bus.start = 1'b1;
        repeat (20) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_done", {63'd0, bus.done}, 64'd0);
        check("midrst_result", bus.result, 64'd0);
        check("midrst_ewait", {63'd0, bus.e_wait}, 64'd0);
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        reset = 1'b1;
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
        check("midrst_nodone", 64'(seen), 64'd0);
        runOp("mul_after_rst", 3'd0, 1'b0, 64'd3, 64'd5, 66, 64'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
